// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Issues the current PC to instruction memory and advances the external PC unit on every
// accepted request. Returned instructions are kept with their PC in an in-order queue until
// decode takes them. An EX-stage redirect flushes the queue, marks in-flight responses for
// discard and steers the PC unit to the redirect target.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   PC                  current PC from the PC unit
//   PCWrite             PC unit advances this edge (PC+4, or BranchTarget when BranchTaken)
//   BranchTaken         PC unit loads BranchTarget this edge
//   BranchTarget        redirect target (0 when no redirect)
//   imem_req_*          fetch request (valid/ready), address = PC
//   imem_rsp_*          in-order fetch response, no backpressure
//   redirect_valid/_target  EX-stage redirect pulse and target
//   instr_valid/_data/_pc/_ready  head of the queue towards decode (valid/ready)
module fetch_unit #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    PC,
  output logic               PCWrite,
  output logic               BranchTaken,
  output logic [XLEN-1:0]    BranchTarget,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [XLEN-1:0]    instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   sum_t;

  localparam ptr_t PtrOne = ptr_t'(1);
  localparam cnt_t CntOne = cnt_t'(1);
  localparam sum_t SumOne = sum_t'(1);
  localparam sum_t DepthW = sum_t'(DEPTH);

  // Queue storage
  logic [XLEN-1:0]    pc_q     [DEPTH];
  logic [INSTR_W-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0]   filled_q;

  // head: next to decode, fill: next to receive a response, tail: next to allocate
  ptr_t head_q, head_d;
  ptr_t fill_q, fill_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;  // allocated entries
  cnt_t pend_q, pend_d;    // allocated entries still waiting for their response
  cnt_t drop_q, drop_d;    // in-flight responses that belong to a squashed path

  logic fire;
  logic pop;
  logic rsp_drop;
  logic rsp_fill;
  sum_t occupancy;
  sum_t drop_sum;

  // Request side / PC unit controls. Everything is forced low while reset is held so the
  // outputs go quiet immediately, not at the next edge.
  always_comb begin
    occupancy      = {1'b0, count_q} + {1'b0, drop_q};
    imem_req_valid = reset && !redirect_valid && (occupancy < DepthW);
    imem_req_addr  = PC;
    fire           = imem_req_valid && imem_req_ready;
    BranchTaken    = reset && redirect_valid;
    BranchTarget   = BranchTaken ? redirect_target : '0;
    PCWrite        = fire || BranchTaken;
  end

  // Decode side
  always_comb begin
    instr_valid = (count_q != '0) && filled_q[head_q];
    instr_data  = data_q[head_q];
    instr_pc    = pc_q[head_q];
    pop         = instr_valid && instr_ready;
  end

  // A response is consumed by the drop counter first; one with nothing outstanding is ignored.
  always_comb begin
    rsp_drop = imem_rsp_valid && (drop_q != '0);
    rsp_fill = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);
  end

  always_comb begin
    head_d   = head_q;
    fill_d   = fill_q;
    tail_d   = tail_q;
    count_d  = count_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    drop_sum = {1'b0, drop_q} + {1'b0, pend_q};

    if (redirect_valid) begin
      // Every outstanding response is now stale; a same-cycle response is one of them.
      head_d  = '0;
      fill_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pend_d  = '0;
      if (imem_rsp_valid && (drop_sum != '0)) begin
        drop_sum = drop_sum - SumOne;
      end
      drop_d = drop_sum[CntW-1:0];
    end else begin
      if (rsp_drop) begin
        drop_d = drop_q - CntOne;
      end
      if (fire) begin
        tail_d = tail_q + PtrOne;
      end
      if (rsp_fill) begin
        fill_d = fill_q + PtrOne;
      end
      if (pop) begin
        head_d = head_q + PtrOne;
      end
      if (fire && !pop) begin
        count_d = count_q + CntOne;
      end else if (!fire && pop) begin
        count_d = count_q - CntOne;
      end
      if (fire && !rsp_fill) begin
        pend_d = pend_q + CntOne;
      end else if (!fire && rsp_fill) begin
        pend_d = pend_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // fire is already suppressed during a redirect; the fill write must be suppressed explicitly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (fire) begin
        pc_q[tail_q]     <= PC;
        filled_q[tail_q] <= 1'b0;
      end
      if (rsp_fill && !redirect_valid) begin
        data_q[fill_q]   <= imem_rsp_data;
        filled_q[fill_q] <= 1'b1;
      end
    end
  end

endmodule
